// File: rtl/sdr_app_bram_responder_pkg.sv
// Shared widths and FSM state encoding for the BRAM-backed SDRAM application responder.
package sdr_app_bram_responder_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 21;
  localparam int DM_W   = DATA_W / 8;
  localparam int TMR_W  = 16;

  typedef enum logic [1:0] {
    SDR_ST_INIT    = 2'd0,
    SDR_ST_IDLE    = 2'd1,
    SDR_ST_REFRESH = 2'd2
  } sdr_state_e;

endpackage

// File: rtl/sdr_app_bram_responder_if.sv
// App-side command bus and Sdr-side response/status signals of the responder.
interface sdr_app_bram_responder_if;
  import sdr_app_bram_responder_pkg::*;

  logic              App_ref_req;
  logic              App_wr_en;
  logic [ADDR_W-1:0] App_wr_addr;
  logic [DM_W-1:0]   App_wr_dm;
  logic [DATA_W-1:0] App_wr_din;
  logic              App_rd_en;
  logic [ADDR_W-1:0] App_rd_addr;
  logic              Sdr_rd_en;
  logic [DATA_W-1:0] Sdr_rd_dout;
  logic              Sdr_init_done;
  logic              Sdr_init_ref_vld;
  logic              Sdr_busy;
  logic              drop_err;

  modport master (
    output App_ref_req, App_wr_en, App_wr_addr, App_wr_dm, App_wr_din, App_rd_en, App_rd_addr,
    input  Sdr_rd_en, Sdr_rd_dout, Sdr_init_done, Sdr_init_ref_vld, Sdr_busy, drop_err
  );

  modport slave (
    input  App_ref_req, App_wr_en, App_wr_addr, App_wr_dm, App_wr_din, App_rd_en, App_rd_addr,
    output Sdr_rd_en, Sdr_rd_dout, Sdr_init_done, Sdr_init_ref_vld, Sdr_busy, drop_err
  );

endinterface

// File: rtl/sdr_app_bram_responder_bram_be.sv
// Single-port byte-masked RAM with one-cycle registered read, write-first on collision.
module sdr_app_bram_responder_bram_be #(
  parameter int DATA_W = 32,
  parameter int DM_W   = 4,
  parameter int AW     = 12
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DM_W-1:0]   wr_mask,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**AW];
  logic [DATA_W-1:0] word_d;
  logic [DATA_W-1:0] rdata_q;

  // Merged word feeds both the array and the read register, giving write-first.
  always_comb begin
    word_d = mem_q[addr];
    if (we) begin
      for (int b = 0; b < DM_W; b++) begin
        if (!wr_mask[b]) word_d[8*b +: 8] = wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en && we) mem_q[addr] <= word_d;
    if (en) rdata_q <= word_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sdr_app_bram_responder.sv
// SDRAM-controller stand-in: init delay, periodic refresh busy windows and fixed
// read latency in front of an on-chip byte-masked RAM.
module sdr_app_bram_responder
  import sdr_app_bram_responder_pkg::*;
#(
  parameter int MEM_AW      = 12,
  parameter int INIT_CYCLES = 200,
  parameter int REF_PERIOD  = 780,
  parameter int REF_BUSY    = 8,
  parameter int RD_LAT      = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  sdr_app_bram_responder_if.slave app
);

  sdr_state_e        state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              init_done_q, init_done_d;
  logic              drop_err_q, drop_err_d;
  logic [RD_LAT-2:0] vld_q, vld_d;
  logic              rd_en_q, rd_en_d;
  logic [DATA_W-1:0] rd_dout_q, rd_dout_d;

  logic              tmr_tc, ref_entry, busy, wr_acc, rd_acc;
  logic [MEM_AW-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata, rd_dat_last;
  logic              unused_addr_hi;

  assign tmr_tc    = (tmr_q == '0);
  assign ref_entry = (state_q == SDR_ST_IDLE) && (tmr_tc || app.App_ref_req);
  assign busy      = (state_q != SDR_ST_IDLE) || ref_entry;
  assign wr_acc    = app.App_wr_en && !busy;
  assign rd_acc    = app.App_rd_en && !app.App_wr_en && !busy;

  // One down-counter serves init wait, refresh interval and refresh duration.
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q - TMR_W'(1);
    init_done_d = init_done_q;
    unique case (state_q)
      SDR_ST_INIT: begin
        if (tmr_tc) begin
          state_d     = SDR_ST_IDLE;
          tmr_d       = TMR_W'(REF_PERIOD - 1);
          init_done_d = 1'b1;
        end
      end
      SDR_ST_IDLE: begin
        if (ref_entry) begin
          state_d = SDR_ST_REFRESH;
          tmr_d   = TMR_W'(REF_BUSY - 1);
        end
      end
      SDR_ST_REFRESH: begin
        if (tmr_tc) begin
          state_d = SDR_ST_IDLE;
          tmr_d   = TMR_W'(REF_PERIOD - 1);
        end
      end
      default: begin
        state_d = SDR_ST_INIT;
        tmr_d   = TMR_W'(INIT_CYCLES - 1);
      end
    endcase
  end

  always_comb begin
    drop_err_d = drop_err_q
               | (app.App_wr_en & busy)
               | (app.App_rd_en & (busy | app.App_wr_en));
    vld_d      = '0;
    vld_d[0]   = rd_acc;
    for (int i = 1; i < RD_LAT - 1; i++) vld_d[i] = vld_q[i-1];
    rd_en_d    = vld_q[RD_LAT-2];
    rd_dout_d  = vld_q[RD_LAT-2] ? rd_dat_last : rd_dout_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SDR_ST_INIT;
      tmr_q       <= TMR_W'(INIT_CYCLES - 1);
      init_done_q <= 1'b0;
      drop_err_q  <= 1'b0;
      vld_q       <= '0;
      rd_en_q     <= 1'b0;
      rd_dout_q   <= '0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      init_done_q <= init_done_d;
      drop_err_q  <= drop_err_d;
      vld_q       <= vld_d;
      rd_en_q     <= rd_en_d;
      rd_dout_q   <= rd_dout_d;
    end
  end

  // RAM output is the first data stage; remaining stages track vld_q one-for-one.
  generate
    if (RD_LAT == 2) begin : g_no_dpipe
      assign rd_dat_last = ram_rdata;
    end else begin : g_dpipe
      logic [DATA_W-1:0] dat_q [RD_LAT-2];
      logic [DATA_W-1:0] dat_d [RD_LAT-2];
      always_comb begin
        dat_d[0] = ram_rdata;
        for (int i = 1; i < RD_LAT - 2; i++) dat_d[i] = dat_q[i-1];
      end
      always_ff @(posedge clk) dat_q <= dat_d;
      assign rd_dat_last = dat_q[RD_LAT-3];
    end
  endgenerate

  assign ram_addr = wr_acc ? app.App_wr_addr[MEM_AW-1:0] : app.App_rd_addr[MEM_AW-1:0];
  assign unused_addr_hi = ^{app.App_wr_addr[ADDR_W-1:MEM_AW], app.App_rd_addr[ADDR_W-1:MEM_AW]};

  sdr_app_bram_responder_bram_be #(
    .DATA_W (DATA_W),
    .DM_W   (DM_W),
    .AW     (MEM_AW)
  ) u_sdr_bram_be (
    .clk     (clk),
    .en      (wr_acc | rd_acc),
    .we      (wr_acc),
    .addr    (ram_addr),
    .wr_mask (app.App_wr_dm),
    .wdata   (app.App_wr_din),
    .rdata   (ram_rdata)
  );

  assign app.Sdr_rd_en        = rd_en_q;
  assign app.Sdr_rd_dout      = rd_dout_q;
  assign app.Sdr_init_done    = init_done_q;
  assign app.Sdr_init_ref_vld = (state_q != SDR_ST_IDLE);
  assign app.Sdr_busy         = busy;
  assign app.drop_err         = drop_err_q;

endmodule

// File: tb/tb_sdr_app_bram_responder.sv
// Directed self-checking bench for sdr_app_bram_responder with default parameters.
module tb_sdr_app_bram_responder;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  sdr_app_bram_responder_if bus();

  sdr_app_bram_responder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .app   (bus)
  );

  always #5 clk = ~clk;

  // cyc counts rising edges since the last reset release; sampling is 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    bus.App_ref_req = 1'b0;
    bus.App_wr_en   = 1'b0;
    bus.App_wr_addr = '0;
    bus.App_wr_dm   = '0;
    bus.App_wr_din  = '0;
    bus.App_rd_en   = 1'b0;
    bus.App_rd_addr = '0;
  endtask

  task automatic do_write(input logic [20:0] a, input logic [31:0] d, input logic [3:0] dm);
    bus.App_wr_en = 1'b1; bus.App_wr_addr = a; bus.App_wr_din = d; bus.App_wr_dm = dm;
    tick();
    bus.App_wr_en = 1'b0;
  endtask

  // Issues one read and reports the cycle offset of the first Sdr_rd_en pulse (-1 if none within 8).
  task automatic do_read(input logic [20:0] a, output int lat, output logic [31:0] d);
    lat = -1;
    d   = 32'h0;
    bus.App_rd_en = 1'b1; bus.App_rd_addr = a;
    tick();
    bus.App_rd_en = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (bus.Sdr_rd_en === 1'b1 && lat < 0) begin lat = k; d = bus.Sdr_rd_dout; end
      if (k < 8) tick();
    end
  endtask

  task automatic test_reset();
    int errs;
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) tick();
    total++; if (bus.Sdr_init_done !== 1'b0) begin bad++; $display("FAIL rst_init_done got=%b exp=0", bus.Sdr_init_done); end
    total++; if (bus.Sdr_init_ref_vld !== 1'b1) begin bad++; $display("FAIL rst_init_ref_vld got=%b exp=1", bus.Sdr_init_ref_vld); end
    total++; if (bus.Sdr_busy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%b exp=1", bus.Sdr_busy); end
    total++; if (bus.Sdr_rd_en !== 1'b0) begin bad++; $display("FAIL rst_rd_en got=%b exp=0", bus.Sdr_rd_en); end
    total++; if (bus.Sdr_rd_dout !== 32'h0) begin bad++; $display("FAIL rst_rd_dout got=%h exp=0", bus.Sdr_rd_dout); end
    total++; if (bus.drop_err !== 1'b0) begin bad++; $display("FAIL rst_drop_err got=%b exp=0", bus.drop_err); end
    rst_n = 1'b1;
    cyc = 0;
    errs = 0;
    for (int n = 1; n < 200; n++) begin
      tick();
      if (bus.Sdr_init_done !== 1'b0 || bus.Sdr_busy !== 1'b1 || bus.Sdr_init_ref_vld !== 1'b1) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL init_wait bad_cycles=%0d exp=0", errs); end
    tick();
    total++; if (bus.Sdr_init_done !== 1'b1) begin bad++; $display("FAIL init_done_200 got=%b exp=1", bus.Sdr_init_done); end
    total++; if (bus.Sdr_busy !== 1'b0) begin bad++; $display("FAIL busy_200 got=%b exp=0", bus.Sdr_busy); end
    total++; if (bus.Sdr_init_ref_vld !== 1'b0) begin bad++; $display("FAIL init_ref_vld_200 got=%b exp=0", bus.Sdr_init_ref_vld); end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] d;
    do_write(21'h10, 32'hDEADBEEF, 4'h0);
    do_read(21'h10, lat, d);
    total++; if (lat != 4) begin bad++; $display("FAIL wr_rd_latency got=%0d exp=4", lat); end
    total++; if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rd_data got=%h exp=deadbeef", d); end
  endtask

  task automatic test_byte_mask();
    int lat; logic [31:0] d;
    do_write(21'h20, 32'hAABBCCDD, 4'h0);
    do_write(21'h20, 32'h11223344, 4'b0101);
    do_read(21'h20, lat, d);
    total++; if (lat != 4) begin bad++; $display("FAIL mask_latency got=%0d exp=4", lat); end
    total++; if (d !== 32'h11BB33DD) begin bad++; $display("FAIL mask_data got=%h exp=11bb33dd", d); end
  endtask

  task automatic test_back_to_back();
    logic exp_v; logic [31:0] exp_d;
    for (int k = 0; k < 8; k++) do_write(21'(k), 32'hC0DE0000 + 32'(k), 4'h0);
    for (int k = 0; k < 12; k++) begin
      if (k < 8) begin bus.App_rd_en = 1'b1; bus.App_rd_addr = 21'(k); end
      else bus.App_rd_en = 1'b0;
      tick();
      exp_v = (k + 1 >= 4) && (k + 1 <= 11);
      total++; if (bus.Sdr_rd_en !== exp_v) begin bad++; $display("FAIL b2b_rd_en_%0d got=%b exp=%b", k + 1, bus.Sdr_rd_en, exp_v); end
      if (exp_v) begin
        exp_d = 32'hC0DE0000 + 32'(k - 3);
        total++; if (bus.Sdr_rd_dout !== exp_d) begin bad++; $display("FAIL b2b_data_%0d got=%h exp=%h", k + 1, bus.Sdr_rd_dout, exp_d); end
      end
    end
  endtask

  task automatic test_alias();
    int lat; logic [31:0] d;
    do_write(21'h01040, 32'h5A5A1234, 4'h0);
    do_read(21'h00040, lat, d);
    total++; if (d !== 32'h5A5A1234 || lat != 4) begin bad++; $display("FAIL alias got=%h lat=%0d exp=5a5a1234 lat=4", d, lat); end
  endtask

  task automatic test_refresh_timer();
    int nbusy; int lat; logic [31:0] d; logic eb, ev;
    do_write(21'h30, 32'h0BADF00D, 4'h0);
    while (cyc < 978) tick();
    total++; if (bus.Sdr_busy !== 1'b0) begin bad++; $display("FAIL busy_before_ref got=%b exp=0", bus.Sdr_busy); end
    total++; if (bus.drop_err !== 1'b0) begin bad++; $display("FAIL drop_before_ref got=%b exp=0", bus.drop_err); end
    tick();
    nbusy = 0;
    bus.App_wr_addr = 21'h30; bus.App_wr_din = 32'hFFFFFFFF; bus.App_wr_dm = 4'h0; bus.App_wr_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (cyc == 988) bus.App_wr_en = 1'b0;
      eb = (cyc >= 979) && (cyc <= 987);
      ev = (cyc >= 980) && (cyc <= 987);
      total++; if (bus.Sdr_busy !== eb) begin bad++; $display("FAIL ref_busy_c%0d got=%b exp=%b", cyc, bus.Sdr_busy, eb); end
      total++; if (bus.Sdr_init_ref_vld !== ev) begin bad++; $display("FAIL ref_vld_c%0d got=%b exp=%b", cyc, bus.Sdr_init_ref_vld, ev); end
      if (bus.Sdr_busy === 1'b1) nbusy++;
      tick();
    end
    bus.App_wr_en = 1'b0;
    total++; if (nbusy != 9) begin bad++; $display("FAIL ref_busy_len got=%0d exp=9", nbusy); end
    total++; if (bus.drop_err !== 1'b1) begin bad++; $display("FAIL ref_drop_err got=%b exp=1", bus.drop_err); end
    do_read(21'h30, lat, d);
    total++; if (d !== 32'h0BADF00D || lat != 4) begin bad++; $display("FAIL ref_dropped_write got=%h lat=%0d exp=0badf00d lat=4", d, lat); end
  endtask

  task automatic test_ref_req();
    bus.App_ref_req = 1'b1;
    #1;
    total++; if (bus.Sdr_busy !== 1'b1) begin bad++; $display("FAIL refreq_busy got=%b exp=1", bus.Sdr_busy); end
    tick();
    bus.App_ref_req = 1'b0;
    total++; if (bus.Sdr_init_ref_vld !== 1'b1) begin bad++; $display("FAIL refreq_enter got=%b exp=1", bus.Sdr_init_ref_vld); end
    repeat (7) tick();
    total++; if (bus.Sdr_init_ref_vld !== 1'b1) begin bad++; $display("FAIL refreq_last got=%b exp=1", bus.Sdr_init_ref_vld); end
    tick();
    total++; if (bus.Sdr_init_ref_vld !== 1'b0 || bus.Sdr_busy !== 1'b0) begin bad++; $display("FAIL refreq_exit vld=%b busy=%b exp=0/0", bus.Sdr_init_ref_vld, bus.Sdr_busy); end
  endtask

  task automatic test_reset_mid_read();
    int npulse;
    bus.App_rd_en = 1'b1; bus.App_rd_addr = 21'h10; tick();
    bus.App_rd_addr = 21'h20; tick();
    bus.App_rd_addr = 21'h30; tick();
    bus.App_rd_en = 1'b0;
    rst_n = 1'b0;
    #1;
    total++; if (bus.Sdr_rd_dout !== 32'h0) begin bad++; $display("FAIL midrst_dout got=%h exp=0", bus.Sdr_rd_dout); end
    total++; if (bus.Sdr_init_done !== 1'b0) begin bad++; $display("FAIL midrst_init_done got=%b exp=0", bus.Sdr_init_done); end
    total++; if (bus.drop_err !== 1'b0) begin bad++; $display("FAIL midrst_drop_err got=%b exp=0", bus.drop_err); end
    npulse = 0;
    repeat (2) begin tick(); if (bus.Sdr_rd_en === 1'b1) npulse++; end
    rst_n = 1'b1;
    cyc = 0;
    repeat (10) begin tick(); if (bus.Sdr_rd_en === 1'b1) npulse++; end
    total++; if (npulse != 0) begin bad++; $display("FAIL midrst_pulses got=%0d exp=0", npulse); end
    total++; if (bus.Sdr_rd_dout !== 32'h0) begin bad++; $display("FAIL midrst_dout_after got=%h exp=0", bus.Sdr_rd_dout); end
  endtask

  task automatic test_after_reset_and_collision();
    int lat; int npulse; logic [31:0] d;
    while (cyc < 200) tick();
    total++; if (bus.Sdr_init_done !== 1'b1) begin bad++; $display("FAIL reinit_done got=%b exp=1", bus.Sdr_init_done); end
    do_read(21'h10, lat, d);
    total++; if (d !== 32'hDEADBEEF || lat != 4) begin bad++; $display("FAIL ram_kept got=%h lat=%0d exp=deadbeef lat=4", d, lat); end
    total++; if (bus.drop_err !== 1'b0) begin bad++; $display("FAIL coll_drop_pre got=%b exp=0", bus.drop_err); end
    bus.App_wr_en = 1'b1; bus.App_wr_addr = 21'h50; bus.App_wr_din = 32'h600DCAFE; bus.App_wr_dm = 4'h0;
    bus.App_rd_en = 1'b1; bus.App_rd_addr = 21'h10;
    tick();
    bus.App_wr_en = 1'b0; bus.App_rd_en = 1'b0;
    total++; if (bus.drop_err !== 1'b1) begin bad++; $display("FAIL coll_drop_err got=%b exp=1", bus.drop_err); end
    npulse = 0;
    repeat (6) begin tick(); if (bus.Sdr_rd_en === 1'b1) npulse++; end
    total++; if (npulse != 0) begin bad++; $display("FAIL coll_read_dropped pulses=%0d exp=0", npulse); end
    do_read(21'h50, lat, d);
    total++; if (d !== 32'h600DCAFE || lat != 4) begin bad++; $display("FAIL coll_write_won got=%h lat=%0d exp=600dcafe lat=4", d, lat); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_mask();
    test_back_to_back();
    test_alias();
    test_refresh_timer();
    test_ref_req();
    test_reset_mid_read();
    test_after_reset_and_collision();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
